// File: rtl/si5338_cfg_seq_if.sv
// Si5338 configuration sequencer <-> I2C byte engine link.
// master: the sequencer issuing commands; slave: the byte engine answering them.
interface si5338_cfg_seq_if;
  logic [1:0] iic_cmd;    // [0]=write, [1]=read; level, to engine Start_Sig
  logic [7:0] iic_addr;   // register address
  logic [7:0] iic_wdata;  // write data
  logic [7:0] iic_rdata;  // read data, valid with iic_done
  logic       iic_done;   // one-cycle completion pulse

  modport master (
    output iic_cmd,
    output iic_addr,
    output iic_wdata,
    input  iic_rdata,
    input  iic_done
  );

  modport slave (
    input  iic_cmd,
    input  iic_addr,
    input  iic_wdata,
    output iic_rdata,
    output iic_done
  );
endinterface

// File: rtl/si5338_cfg_seq.sv
// Table-driven Si5338 configuration sequencer.
// Walks a register table of {op, reg, val, mask} entries and issues single-byte
// I2C write/read commands: plain writes, read-modify-writes, status polls and
// timed delays. Sticky cfg_done/cfg_err gate the downstream clock domain release.
module si5338_cfg_seq #(
  parameter int unsigned TBL_AW      = 7,
  parameter int unsigned DLY_TICK    = 50000,
  parameter logic [19:0] TXN_TIMEOUT = 20'd200000,
  parameter logic [15:0] POLL_MAX    = 16'd1000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [25:0]       tbl_data,
  si5338_cfg_seq_if.master  iic,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [TBL_AW-1:0] err_idx
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_RD,
    ST_MERGE,
    ST_WR,
    ST_POLL_RD,
    ST_POLL_CHK,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_POLL  = 2'd1,
    OP_DELAY = 2'd2,
    OP_END   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_WR   = 2'b01,
    CMD_RD   = 2'b10
  } cmd_e;

  state_e              state_q, state_d;
  logic                fetch_ph_q, fetch_ph_d;
  logic [TBL_AW-1:0]   idx_q, idx_d;
  logic [TBL_AW-1:0]   tbl_addr_q, tbl_addr_d;
  logic [25:0]         entry_q, entry_d;
  cmd_e                cmd_q, cmd_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          rdata_q, rdata_d;
  logic [19:0]         txn_cnt_q, txn_cnt_d;
  logic [15:0]         poll_cnt_q, poll_cnt_d;
  logic [31:0]         dly_cnt_q, dly_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [TBL_AW-1:0]   err_idx_q, err_idx_d;

  // Decoded fields of the captured table entry
  op_e        ent_op;
  logic [7:0] ent_reg;
  logic [7:0] ent_val;
  logic [7:0] ent_mask;
  logic       txn_expired;
  logic       poll_match;
  logic       go_err;
  logic       go_done;

  assign ent_op      = op_e'(entry_q[25:24]);
  assign ent_reg     = entry_q[23:16];
  assign ent_val     = entry_q[15:8];
  assign ent_mask    = entry_q[7:0];
  assign txn_expired = (txn_cnt_q == TXN_TIMEOUT - 20'd1);
  assign poll_match  = ((rdata_q & ent_mask) == (ent_val & ent_mask));

  // Next-state and datapath updates for the table walk
  always_comb begin
    state_d    = state_q;
    fetch_ph_d = fetch_ph_q;
    idx_d      = idx_q;
    tbl_addr_d = tbl_addr_q;
    entry_d    = entry_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    txn_cnt_d  = txn_cnt_q;
    poll_cnt_d = poll_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    go_err     = 1'b0;
    go_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d      = '0;
          tbl_addr_d = '0;
          fetch_ph_d = 1'b0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      // First cycle presents tbl_addr, second cycle captures the ROM output
      ST_FETCH: begin
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          entry_d    = tbl_data;
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        txn_cnt_d = '0;
        case (ent_op)
          OP_WRITE: begin
            addr_d = ent_reg;
            if (ent_mask == 8'hFF) begin
              wdata_d = ent_val;
              cmd_d   = CMD_WR;
              state_d = ST_WR;
            end else begin
              cmd_d   = CMD_RD;
              state_d = ST_RD;
            end
          end
          OP_POLL: begin
            addr_d     = ent_reg;
            cmd_d      = CMD_RD;
            poll_cnt_d = '0;
            state_d    = ST_POLL_RD;
          end
          OP_DELAY: begin
            if (ent_val == 8'h00) begin
              state_d = ST_NEXT;
            end else begin
              dly_cnt_d = 32'(ent_val) * DLY_TICK;
              state_d   = ST_DELAY;
            end
          end
          default: go_done = 1'b1;
        endcase
      end

      ST_RD: begin
        if (iic.iic_done) begin
          rdata_d = iic.iic_rdata;
          cmd_d   = CMD_NONE;
          state_d = ST_MERGE;
        end else if (txn_expired) begin
          go_err = 1'b1;
        end else begin
          txn_cnt_d = txn_cnt_q + 20'd1;
        end
      end

      ST_MERGE: begin
        wdata_d   = (rdata_q & ~ent_mask) | (ent_val & ent_mask);
        cmd_d     = CMD_WR;
        txn_cnt_d = '0;
        state_d   = ST_WR;
      end

      ST_WR: begin
        if (iic.iic_done) begin
          cmd_d   = CMD_NONE;
          state_d = ST_NEXT;
        end else if (txn_expired) begin
          go_err = 1'b1;
        end else begin
          txn_cnt_d = txn_cnt_q + 20'd1;
        end
      end

      ST_POLL_RD: begin
        if (iic.iic_done) begin
          rdata_d    = iic.iic_rdata;
          cmd_d      = CMD_NONE;
          poll_cnt_d = poll_cnt_q + 16'd1;
          state_d    = ST_POLL_CHK;
        end else if (txn_expired) begin
          go_err = 1'b1;
        end else begin
          txn_cnt_d = txn_cnt_q + 20'd1;
        end
      end

      // A match on the last allowed read still counts as success
      ST_POLL_CHK: begin
        if (poll_match) begin
          state_d = ST_NEXT;
        end else if (poll_cnt_q >= POLL_MAX) begin
          go_err = 1'b1;
        end else begin
          cmd_d     = CMD_RD;
          txn_cnt_d = '0;
          state_d   = ST_POLL_RD;
        end
      end

      ST_DELAY: begin
        if (dly_cnt_q <= 32'd1) begin
          state_d = ST_NEXT;
        end else begin
          dly_cnt_d = dly_cnt_q - 32'd1;
        end
      end

      // The last table slot ends the walk instead of wrapping to entry 0
      ST_NEXT: begin
        if (idx_q == '1) begin
          go_done = 1'b1;
        end else begin
          idx_d      = idx_q + TBL_AW'(1);
          tbl_addr_d = idx_q + TBL_AW'(1);
          state_d    = ST_FETCH;
        end
      end

      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Terminal transitions update the status flags on entry so they are
    // already registered while DONE/ERROR is occupied.
    if (go_done) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = ST_DONE;
    end
    if (go_err) begin
      err_d     = 1'b1;
      err_idx_d = idx_q;
      busy_d    = 1'b0;
      cmd_d     = CMD_NONE;
      state_d   = ST_ERROR;
    end
  end

  // State and output registers, asynchronously cleared by RSTn
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      fetch_ph_q <= 1'b0;
      idx_q      <= '0;
      tbl_addr_q <= '0;
      entry_q    <= '0;
      cmd_q      <= CMD_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      txn_cnt_q  <= '0;
      poll_cnt_q <= '0;
      dly_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_ph_q <= fetch_ph_d;
      idx_q      <= idx_d;
      tbl_addr_q <= tbl_addr_d;
      entry_q    <= entry_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      txn_cnt_q  <= txn_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  // Command is masked in the done cycle so the engine cannot re-latch it
  assign iic.iic_cmd   = cmd_q & {2{~iic.iic_done}};
  assign iic.iic_addr  = addr_q;
  assign iic.iic_wdata = wdata_q;
  assign tbl_addr      = tbl_addr_q;
  assign busy          = busy_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign err_idx       = err_idx_q;

endmodule

// File: tb/tb_si5338_cfg_seq.sv
// Self-checking bench for si5338_cfg_seq: table ROM model, I2C engine model
// with a scoreboard of expected commands, and directed configuration scenarios.
module tb_si5338_cfg_seq;
  localparam int unsigned AW      = 7;
  localparam int unsigned DT      = 10;
  localparam logic [19:0] TO      = 20'd50;
  localparam logic [15:0] PM      = 16'd4;
  localparam int          ENG_LAT = 3;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [AW-1:0] err_idx;
  logic [25:0]   tbl_data;
  logic          busy, cfg_done, cfg_err;

  si5338_cfg_seq_if iic();

  si5338_cfg_seq #(
    .TBL_AW(AW), .DLY_TICK(DT), .TXN_TIMEOUT(TO), .POLL_MAX(PM)
  ) u_dut (
    .CLK(CLK), .RSTn(RSTn), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .iic(iic.master),
    .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_idx(err_idx)
  );

  always #5 CLK = ~CLK;

  // Synchronous table ROM: data valid one cycle after address
  logic [25:0] tbl [0:127];
  always @(posedge CLK) tbl_data <= tbl[tbl_addr];

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [7:0]  rd_q[$];
  int          errors = 0;
  int          checks = 0;
  int          eng_mute_at = -1;
  int          eng_ncmd = 0;
  int unsigned last_cmd_cyc = 0;
  int unsigned err_cyc = 0;
  int          first_seen [0:127];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] ent(input logic [1:0] op, input logic [7:0] r,
                                      input logic [7:0] v, input logic [7:0] m);
    return {op, r, v, m};
  endfunction

  task automatic clear_tbl();
    for (int i = 0; i < 128; i++) tbl[i] = ent(2'd3, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{cmd: 2'b01, addr: a, wdata: d});
  endtask

  task automatic exp_rd(input logic [7:0] a, input logic [7:0] rdata);
    exp_q.push_back('{cmd: 2'b10, addr: a, wdata: 8'h00});
    rd_q.push_back(rdata);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Wait (bounded) for cfg_done or cfg_err, recording when each table address first appears
  task automatic run(input string tag, input int bound);
    bit finished;
    finished = 1'b0;
    for (int i = 0; i < 128; i++) first_seen[i] = -1;
    for (int n = 0; n < bound; n++) begin
      @(negedge CLK);
      if (first_seen[tbl_addr] < 0) first_seen[tbl_addr] = n;
      if (cfg_err) err_cyc = cyc;
      if (cfg_done || cfg_err) begin
        finished = 1'b1;
        break;
      end
    end
    chk({tag, "_finished"}, {31'b0, finished}, 32'd1);
  endtask

  // I2C byte engine model: latches a command, answers ENG_LAT cycles later
  initial begin : engine
    bit         active;
    bit         silent;
    int         wait_n;
    logic [1:0] lat_cmd;
    logic [7:0] lat_addr, lat_wdata, lat_rd;
    txn_t       e;
    active = 1'b0;
    silent = 1'b0;
    wait_n = 0;
    lat_cmd = 2'b00; lat_addr = 8'h00; lat_wdata = 8'h00; lat_rd = 8'h00;
    iic.iic_done  = 1'b0;
    iic.iic_rdata = 8'h00;
    forever begin
      @(negedge CLK);
      iic.iic_done = 1'b0;
      if (!RSTn) begin
        active = 1'b0;
      end else if (!active) begin
        if (iic.iic_cmd != 2'b00) begin
          lat_cmd = iic.iic_cmd; lat_addr = iic.iic_addr; lat_wdata = iic.iic_wdata;
          last_cmd_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_cmd", {30'b0, iic.iic_cmd}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("cmd_kind", {30'b0, iic.iic_cmd}, {30'b0, e.cmd});
            chk("cmd_addr", {24'b0, iic.iic_addr}, {24'b0, e.addr});
            if (e.cmd == 2'b01) chk("cmd_wdata", {24'b0, iic.iic_wdata}, {24'b0, e.wdata});
          end
          lat_rd = 8'h00;
          if (lat_cmd == 2'b10 && rd_q.size() > 0) lat_rd = rd_q.pop_front();
          silent = (eng_ncmd == eng_mute_at);
          eng_ncmd++;
          wait_n = ENG_LAT;
          active = 1'b1;
        end
      end else if (silent && iic.iic_cmd == 2'b00) begin
        active = 1'b0;
      end else begin
        chk("hold_cmd", {30'b0, iic.iic_cmd}, {30'b0, lat_cmd});
        chk("hold_addr", {24'b0, iic.iic_addr}, {24'b0, lat_addr});
        chk("hold_wdata", {24'b0, iic.iic_wdata}, {24'b0, lat_wdata});
        if (!silent) begin
          wait_n--;
          if (wait_n == 0) begin
            iic.iic_rdata = lat_rd;
            iic.iic_done  = 1'b1;
            active = 1'b0;
            #1;
            chk("cmd_gated_in_done", {30'b0, iic.iic_cmd}, 32'd0);
          end
        end
      end
    end
  end

  initial begin : stim
    bit seen;
    clear_tbl();
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tbl_addr", {25'b0, tbl_addr}, 32'd0);
    chk("rst_iic_cmd", {30'b0, iic.iic_cmd}, 32'd0);
    chk("rst_iic_addr", {24'b0, iic.iic_addr}, 32'd0);
    chk("rst_iic_wdata", {24'b0, iic.iic_wdata}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cfg_done", {31'b0, cfg_done}, 32'd0);
    chk("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
    chk("rst_err_idx", {25'b0, err_idx}, 32'd0);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Plain write then END
    tbl[0] = ent(2'd0, 8'hE6, 8'h10, 8'hFF);
    exp_wr(8'hE6, 8'h10);
    pulse_start();
    chk("t1_busy_after_start", {31'b0, busy}, 32'd1);
    run("t1", 200);
    chk("t1_cfg_done", {31'b0, cfg_done}, 32'd1);
    chk("t1_cfg_err", {31'b0, cfg_err}, 32'd0);
    chk("t1_busy_low", {31'b0, busy}, 32'd0);
    chk("t1_sb_empty", exp_q.size(), 32'd0);
    repeat (2) @(negedge CLK);

    // Read-modify-write: (0x15 & ~0x80) | (0x80 & 0x80) = 0x95
    clear_tbl();
    tbl[0] = ent(2'd0, 8'h31, 8'h80, 8'h80);
    exp_rd(8'h31, 8'h15);
    exp_wr(8'h31, 8'h95);
    pulse_start();
    run("t2", 200);
    chk("t2_cfg_done", {31'b0, cfg_done}, 32'd1);
    chk("t2_sb_empty", exp_q.size(), 32'd0);
    repeat (2) @(negedge CLK);

    // Poll: three mismatches then a match, then the next entry
    clear_tbl();
    tbl[0] = ent(2'd1, 8'hDA, 8'h00, 8'h10);
    tbl[1] = ent(2'd0, 8'h20, 8'h55, 8'hFF);
    repeat (3) exp_rd(8'hDA, 8'h10);
    exp_rd(8'hDA, 8'h00);
    exp_wr(8'h20, 8'h55);
    pulse_start();
    run("t3", 400);
    chk("t3_cfg_done", {31'b0, cfg_done}, 32'd1);
    chk("t3_cfg_err", {31'b0, cfg_err}, 32'd0);
    chk("t3_sb_empty", exp_q.size(), 32'd0);
    chk("t3_rd_left", rd_q.size(), 32'd0);
    repeat (2) @(negedge CLK);

    // Delays: FETCH(2)+DECODE(1)+NEXT(1) overhead, plus val*DLY_TICK in DELAY
    clear_tbl();
    tbl[0] = ent(2'd0, 8'h40, 8'h01, 8'hFF);
    tbl[1] = ent(2'd2, 8'h00, 8'h00, 8'h00);
    tbl[2] = ent(2'd2, 8'h00, 8'h03, 8'h00);
    exp_wr(8'h40, 8'h01);
    pulse_start();
    run("t4", 400);
    chk("t4_cfg_done", {31'b0, cfg_done}, 32'd1);
    chk("t4_delay0_span", 32'(first_seen[2] - first_seen[1]), 32'd4);
    chk("t4_delay3_span", 32'(first_seen[3] - first_seen[2]), 32'd4 + 32'd3 * DT);
    repeat (2) @(negedge CLK);

    // Engine silent on entry 5 -> timeout
    clear_tbl();
    for (int i = 0; i < 6; i++) begin
      tbl[i] = ent(2'd0, 8'h50 + 8'(i), 8'(i), 8'hFF);
      exp_wr(8'h50 + 8'(i), 8'(i));
    end
    eng_mute_at = eng_ncmd + 5;
    pulse_start();
    run("t5", 600);
    chk("t5_cfg_err", {31'b0, cfg_err}, 32'd1);
    chk("t5_cfg_done", {31'b0, cfg_done}, 32'd0);
    chk("t5_err_idx", {25'b0, err_idx}, 32'd5);
    chk("t5_iic_cmd", {30'b0, iic.iic_cmd}, 32'd0);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_timeout_cycles", err_cyc - last_cmd_cyc, 32'(TO));
    chk("t5_sb_empty", exp_q.size(), 32'd0);
    eng_mute_at = -1;
    repeat (3) @(negedge CLK);

    // Poll exhausted after POLL_MAX reads, then a restart replays from entry 0
    clear_tbl();
    tbl[0] = ent(2'd0, 8'h10, 8'hAA, 8'hFF);
    tbl[1] = ent(2'd1, 8'hE8, 8'h01, 8'h01);
    exp_wr(8'h10, 8'hAA);
    repeat (4) exp_rd(8'hE8, 8'h00);
    pulse_start();
    run("t6", 400);
    chk("t6_cfg_err", {31'b0, cfg_err}, 32'd1);
    chk("t6_err_idx", {25'b0, err_idx}, 32'd1);
    chk("t6_sb_empty", exp_q.size(), 32'd0);
    chk("t6_rd_left", rd_q.size(), 32'd0);
    repeat (2) @(negedge CLK);
    exp_wr(8'h10, 8'hAA);
    exp_rd(8'hE8, 8'h01);
    pulse_start();
    chk("t6_err_cleared", {31'b0, cfg_err}, 32'd0);
    chk("t6_done_cleared", {31'b0, cfg_done}, 32'd0);
    chk("t6_busy_restart", {31'b0, busy}, 32'd1);
    run("t6b", 400);
    chk("t6b_cfg_done", {31'b0, cfg_done}, 32'd1);
    chk("t6b_cfg_err", {31'b0, cfg_err}, 32'd0);
    chk("t6b_sb_empty", exp_q.size(), 32'd0);
    repeat (2) @(negedge CLK);

    // Last table slot ends the walk without wrapping
    for (int i = 0; i < 128; i++) tbl[i] = ent(2'd2, 8'h00, 8'h00, 8'h00);
    pulse_start();
    run("t7", 2000);
    chk("t7_cfg_done", {31'b0, cfg_done}, 32'd1);
    chk("t7_tbl_addr_last", {25'b0, tbl_addr}, 32'd127);
    chk("t7_sb_empty", exp_q.size(), 32'd0);
    repeat (2) @(negedge CLK);

    // Asynchronous reset while a command is outstanding
    clear_tbl();
    tbl[0] = ent(2'd2, 8'h00, 8'h00, 8'h00);
    tbl[1] = ent(2'd2, 8'h00, 8'h00, 8'h00);
    tbl[2] = ent(2'd0, 8'h77, 8'h33, 8'hFF);
    exp_wr(8'h77, 8'h33);
    eng_mute_at = eng_ncmd;
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (iic.iic_cmd != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t8_cmd_seen", {31'b0, seen}, 32'd1);
    #2;
    RSTn = 1'b0;
    #1;
    chk("t8_rst_iic_cmd", {30'b0, iic.iic_cmd}, 32'd0);
    chk("t8_rst_iic_addr", {24'b0, iic.iic_addr}, 32'd0);
    chk("t8_rst_iic_wdata", {24'b0, iic.iic_wdata}, 32'd0);
    chk("t8_rst_tbl_addr", {25'b0, tbl_addr}, 32'd0);
    chk("t8_rst_busy", {31'b0, busy}, 32'd0);
    chk("t8_rst_cfg_done", {31'b0, cfg_done}, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    eng_mute_at = -1;
    repeat (3) @(negedge CLK);
    chk("t8_idle_busy", {31'b0, busy}, 32'd0);
    chk("t8_idle_cmd", {30'b0, iic.iic_cmd}, 32'd0);
    chk("t8_sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
